// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg
//   Shared definitions for the alu_exec_unit execute/writeback stage:
//   6-bit opcode constants and the control state encoding.
//   Optional feature macro: ALU_EXEC_MUL_EN (adds the MUL_BUSY state).
package alu_exec_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_NOR  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd6;
  localparam logic [5:0] OP_MUL  = 6'd7;
  localparam logic [5:0] OP_STO  = 6'd8;
  localparam logic [5:0] OP_BLE  = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_JMP  = 6'd11;
  localparam logic [5:0] OP_CALL = 6'd12;
  localparam logic [5:0] OP_RET  = 6'd13;
  localparam logic [5:0] OP_PUSH = 6'd14;
  localparam logic [5:0] OP_POP  = 6'd15;
  localparam logic [5:0] OP_OUT  = 6'd16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_PERIPH_WAIT = 2'd1,
`ifdef ALU_EXEC_MUL_EN
    ST_BUBBLE      = 2'd2,
    ST_MUL_BUSY    = 2'd3
`else
    ST_BUBBLE      = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/lifo_stack.sv
// lifo_stack
//   Hardware LIFO used for CALL/RET return addresses and PUSH/POP data.
//   Pushes into a full stack and pops from an empty stack are ignored here;
//   the caller owns the overflow/underflow reporting.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset (pointer only)
//     push, pop        one-cycle requests (never both in the same cycle)
//     push_data        entry written on push
//     pop_data         current top of stack (valid when !empty)
//     full, empty      occupancy status
module lifo_stack #(
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  // One extra pointer bit so that a count of STACK_DEPTH is representable;
  // with a power-of-two depth that extra bit alone means "full".
  logic [PTR_W:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]  wr_idx, top_idx;
  logic [DATA_W-1:0] mem_q [STACK_DEPTH];

  assign wr_idx   = ptr_q[PTR_W-1:0];
  assign top_idx  = wr_idx - PTR_W'(1);
  assign full     = ptr_q[PTR_W];
  assign empty    = (ptr_q == '0);
  assign pop_data = mem_q[top_idx];

  always_comb begin
    ptr_d = ptr_q;
    if (push && !full) begin
      ptr_d = ptr_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr_d = ptr_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute/writeback stage: one decoded instruction per valid/ready
//   handshake. Executes ALU ops, branches, CALL/RET, PUSH/POP against an
//   internal lifo_stack, OUT to a stall-able peripheral and (optionally)
//   an iterative shift-add MUL. All outputs come from registers.
//   Optional feature macro: ALU_EXEC_MUL_EN
//     defined   - MUL takes DATA_W busy cycles and writes the low product bits
//     undefined - MUL behaves as NOP
//   Ports:
//     Clock, Reset (async, active-low)
//     iValid/oReady          instruction handshake, accept on iValid && oReady
//     iOpcode, iDest, iSrcA, iSrcB, iImm, iPC   decoded instruction
//     iPeriphBusy            peripheral sink not ready
//     oWbEn/oWbAddr/oWbData  one-cycle register writeback
//     oRedirect/oRedirectPC  one-cycle PC redirect
//     oPeriphWrite/oPeriphData  one-cycle peripheral strobe
//     oStackOvf, oStackUnf   sticky stack error flags
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int PC_W        = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [5:0]        iOpcode,
  input  logic [ADDR_W-1:0] iDest,
  input  logic [DATA_W-1:0] iSrcA,
  input  logic [DATA_W-1:0] iSrcB,
  input  logic [DATA_W-1:0] iImm,
  input  logic [PC_W-1:0]   iPC,
  input  logic              iPeriphBusy,
  output logic              oWbEn,
  output logic [ADDR_W-1:0] oWbAddr,
  output logic [DATA_W-1:0] oWbData,
  output logic              oRedirect,
  output logic [PC_W-1:0]   oRedirectPC,
  output logic              oPeriphWrite,
  output logic [DATA_W-1:0] oPeriphData,
  output logic              oStackOvf,
  output logic              oStackUnf
);

  state_e            state_q, state_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              redir_q, redir_d;
  logic [PC_W-1:0]   redir_pc_q, redir_pc_d;
  logic              pw_q, pw_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic [DATA_W-1:0] stk_wdata, stk_rdata;
  logic [PC_W-1:0]   pc_plus1;

`ifdef ALU_EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);
  logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;
  logic [DATA_W-1:0] mul_mcand_q, mul_mcand_d;
  logic [DATA_W-1:0] mul_mplier_q, mul_mplier_d;
  logic [DATA_W-1:0] mul_prod_q, mul_prod_d;
  logic [ADDR_W-1:0] mul_dest_q, mul_dest_d;
  logic [DATA_W-1:0] mul_sum;

  // Partial product for this step; only the low DATA_W bits are ever needed.
  assign mul_sum = mul_prod_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
`endif

  assign pc_plus1 = iPC + PC_W'(1);

  lifo_stack #(
    .DATA_W      (DATA_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (Clock),
    .rst_n     (Reset),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (stk_wdata),
    .pop_data  (stk_rdata),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    state_d    = state_q;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    pw_d       = 1'b0;
    pdata_d    = pdata_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_wdata  = iSrcA;
`ifdef ALU_EXEC_MUL_EN
    mul_cnt_d    = mul_cnt_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_prod_d   = mul_prod_q;
    mul_dest_d   = mul_dest_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          case (iOpcode)
            OP_ADD:  begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iSrcA + iSrcB;    end
            OP_SUB:  begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iSrcA - iSrcB;    end
            OP_AND:  begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iSrcA & iSrcB;    end
            OP_OR:   begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iSrcA | iSrcB;    end
            OP_NOR:  begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = ~(iSrcA | iSrcB); end
            OP_ADDI: begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iSrcA + iImm;     end
            OP_STO:  begin wb_en_d = 1'b1; wb_addr_d = iDest; wb_data_d = iImm;             end
            OP_BLE, OP_BEQ, OP_JMP: begin
              if ((iOpcode == OP_JMP) ||
                  ((iOpcode == OP_BLE) && (iSrcA <= iSrcB)) ||
                  ((iOpcode == OP_BEQ) && (iSrcA == iSrcB))) begin
                redir_d    = 1'b1;
                redir_pc_d = iImm[PC_W-1:0];
                state_d    = ST_BUBBLE;
              end
            end
            OP_CALL: begin
              // The return address is dropped on a full stack but the
              // call itself still takes effect.
              stk_push   = 1'b1;
              stk_wdata  = DATA_W'(pc_plus1);
              ovf_d      = ovf_q | stk_full;
              redir_d    = 1'b1;
              redir_pc_d = iImm[PC_W-1:0];
              state_d    = ST_BUBBLE;
            end
            OP_RET: begin
              if (stk_empty) begin
                unf_d = 1'b1;
              end else begin
                stk_pop    = 1'b1;
                redir_d    = 1'b1;
                redir_pc_d = stk_rdata[PC_W-1:0];
                state_d    = ST_BUBBLE;
              end
            end
            OP_PUSH: begin
              stk_push = 1'b1;
              ovf_d    = ovf_q | stk_full;
            end
            OP_POP: begin
              stk_pop   = 1'b1;
              wb_en_d   = 1'b1;
              wb_addr_d = iDest;
              wb_data_d = stk_empty ? '0 : stk_rdata;
              unf_d     = unf_q | stk_empty;
            end
            OP_OUT: begin
              pdata_d = iSrcA;
              if (iPeriphBusy) begin
                state_d = ST_PERIPH_WAIT;
              end else begin
                pw_d = 1'b1;
              end
            end
`ifdef ALU_EXEC_MUL_EN
            OP_MUL: begin
              mul_cnt_d    = '0;
              mul_mcand_d  = iSrcA;
              mul_mplier_d = iSrcB;
              mul_prod_d   = '0;
              mul_dest_d   = iDest;
              state_d      = ST_MUL_BUSY;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_PERIPH_WAIT: begin
        if (!iPeriphBusy) begin
          pw_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_BUBBLE: begin
        state_d = ST_IDLE;
      end
`ifdef ALU_EXEC_MUL_EN
      ST_MUL_BUSY: begin
        mul_prod_d   = mul_sum;
        mul_mcand_d  = mul_mcand_q << 1;
        mul_mplier_d = mul_mplier_q >> 1;
        mul_cnt_d    = mul_cnt_q + CNT_W'(1);
        // Last multiplier bit consumed this edge: write back the final sum.
        if (mul_cnt_q == CNT_W'(DATA_W-1)) begin
          wb_en_d   = 1'b1;
          wb_addr_d = mul_dest_q;
          wb_data_d = mul_sum;
          state_d   = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      pw_q       <= 1'b0;
      pdata_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      mul_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      pw_q       <= pw_d;
      pdata_q    <= pdata_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
`ifdef ALU_EXEC_MUL_EN
      mul_cnt_q  <= mul_cnt_d;
`endif
    end
  end

`ifdef ALU_EXEC_MUL_EN
  // Multiplier datapath is only meaningful while MUL_BUSY, so no reset.
  always_ff @(posedge Clock) begin
    mul_mcand_q  <= mul_mcand_d;
    mul_mplier_q <= mul_mplier_d;
    mul_prod_q   <= mul_prod_d;
    mul_dest_q   <= mul_dest_d;
  end
`endif

  assign oReady       = (state_q == ST_IDLE);
  assign oWbEn        = wb_en_q;
  assign oWbAddr      = wb_addr_q;
  assign oWbData      = wb_data_q;
  assign oRedirect    = redir_q;
  assign oRedirectPC  = redir_pc_q;
  assign oPeriphWrite = pw_q;
  assign oPeriphData  = pdata_q;
  assign oStackOvf    = ovf_q;
  assign oStackUnf    = unf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 16;
  localparam int SD = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          iValid = 1'b0;
  logic          oReady;
  logic [5:0]    iOpcode = '0;
  logic [AW-1:0] iDest = '0;
  logic [DW-1:0] iSrcA = '0, iSrcB = '0, iImm = '0;
  logic [PW-1:0] iPC = '0;
  logic          iPeriphBusy = 1'b0;
  logic          oWbEn, oRedirect, oPeriphWrite, oStackOvf, oStackUnf;
  logic [AW-1:0] oWbAddr;
  logic [DW-1:0] oWbData, oPeriphData;
  logic [PW-1:0] oRedirectPC;

  alu_exec_unit #(.DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .STACK_DEPTH(SD)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iOpcode(iOpcode), .iDest(iDest), .iSrcA(iSrcA), .iSrcB(iSrcB),
    .iImm(iImm), .iPC(iPC), .iPeriphBusy(iPeriphBusy),
    .oWbEn(oWbEn), .oWbAddr(oWbAddr), .oWbData(oWbData),
    .oRedirect(oRedirect), .oRedirectPC(oRedirectPC),
    .oPeriphWrite(oPeriphWrite), .oPeriphData(oPeriphData),
    .oStackOvf(oStackOvf), .oStackUnf(oStackUnf)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Reference stack state: a plain queue with a capacity limit.
  int stk[$];
  bit ovf_m = 0;
  bit unf_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one instruction at a negedge, accept on the next posedge,
  // return at the following negedge (the cycle right after the accept).
  task automatic issue(input logic [5:0] op, input logic [AW-1:0] d,
                       input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] imm, input logic [PW-1:0] pc);
    chk("ready_before_issue", oReady, 1);
    iValid = 1'b1; iOpcode = op; iDest = d; iSrcA = a; iSrcB = b; iImm = imm; iPC = pc;
    @(posedge Clock);
    #1 iValid = 1'b0;
    @(negedge Clock);
  endtask

  function automatic int alu_ref(input logic [5:0] op, input int a, input int b, input int imm);
    case (op)
      OP_ADD:  return (a + b) % 65536;
      OP_SUB:  return (a - b + 65536) % 65536;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return 65535 - (a | b);
      OP_ADDI: return (a + imm) % 65536;
      default: return imm;
    endcase
  endfunction

  task automatic model_push(input int v);
    if (stk.size() < SD) stk.push_back(v);
    else ovf_m = 1;
  endtask

  function automatic int model_pop();
    if (stk.size() == 0) begin
      unf_m = 1;
      return 0;
    end
    return stk.pop_back();
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] alu_ops[7];
    logic [5:0] br_ops[3];
    logic [5:0] op;
    int a, b, imm, exp_v, strobes;
    logic [AW-1:0] d;
    bit taken;
    alu_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_ADDI, OP_STO};
    br_ops  = '{OP_BLE, OP_BEQ, OP_JMP};

    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst_wben", oWbEn, 0);
    chk("rst_wbdata", oWbData, 0);
    chk("rst_redirect", oRedirect, 0);
    chk("rst_periph", oPeriphWrite, 0);
    chk("rst_ovf", oStackOvf, 0);
    chk("rst_unf", oStackUnf, 0);
    Reset = 1'b1;
    @(negedge Clock);
    chk("rst_ready", oReady, 1);

    // Directed ADD with wrap
    issue(OP_ADD, 8'd5, 16'hFFFF, 16'h0002, 16'h0, 16'h0);
    chk("add_wben", oWbEn, 1);
    chk("add_addr", oWbAddr, 5);
    chk("add_data", oWbData, 16'h0001);
    chk("add_noredir", oRedirect, 0);
    @(negedge Clock);
    chk("add_wben_one_cycle", oWbEn, 0);

    // Random single-cycle ALU ops
    for (int i = 0; i < 30; i++) begin
      op = alu_ops[$urandom_range(0, 6)];
      a = int'($urandom_range(0, 65535)); b = int'($urandom_range(0, 65535));
      imm = int'($urandom_range(0, 65535)); d = AW'($urandom_range(0, 255));
      issue(op, d, DW'(a), DW'(b), DW'(imm), '0);
      chk("alu_wben", oWbEn, 1);
      chk("alu_addr", oWbAddr, d);
      chk("alu_data", oWbData, alu_ref(op, a, b, imm));
    end

    // Branches: directed BLE taken / not taken
    issue(OP_BLE, 8'd0, 16'd3, 16'd3, 16'h0040, 16'h0);
    chk("ble_redir", oRedirect, 1);
    chk("ble_pc", oRedirectPC, 16'h0040);
    chk("ble_bubble_ready", oReady, 0);
    chk("ble_nowb", oWbEn, 0);
    @(negedge Clock);
    chk("ble_redir_one_cycle", oRedirect, 0);
    issue(OP_BLE, 8'd0, 16'd4, 16'd3, 16'h0040, 16'h0);
    chk("ble_nt_redir", oRedirect, 0);
    chk("ble_nt_ready", oReady, 1);

    // Random branches on small operands so equality happens often
    for (int i = 0; i < 12; i++) begin
      op = br_ops[$urandom_range(0, 2)];
      a = int'($urandom_range(0, 3)); b = int'($urandom_range(0, 3));
      imm = int'($urandom_range(0, 65535));
      taken = (op == OP_JMP) || (op == OP_BLE && a <= b) || (op == OP_BEQ && a == b);
      issue(op, 8'd1, DW'(a), DW'(b), DW'(imm), '0);
      chk("br_redir", oRedirect, taken);
      chk("br_nowb", oWbEn, 0);
      if (taken) begin
        chk("br_pc", oRedirectPC, imm);
        @(negedge Clock);
      end
    end

    // CALL then RET
    issue(OP_CALL, 8'd0, 16'h0, 16'h0, 16'h0080, 16'h0010);
    model_push(16'h0011);
    chk("call_redir", oRedirect, 1);
    chk("call_pc", oRedirectPC, 16'h0080);
    @(negedge Clock);
    issue(OP_RET, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    exp_v = model_pop();
    chk("ret_redir", oRedirect, 1);
    chk("ret_pc", oRedirectPC, exp_v);
    @(negedge Clock);

    // Five pushes into a 4-deep stack, then five pops
    for (int i = 1; i <= 5; i++) begin
      issue(OP_PUSH, 8'd0, DW'(i), 16'h0, 16'h0, 16'h0);
      model_push(i);
      chk("push_nowb", oWbEn, 0);
    end
    chk("push_ovf", oStackOvf, ovf_m);
    for (int i = 0; i < 5; i++) begin
      issue(OP_POP, AW'(i + 10), 16'h0, 16'h0, 16'h0, 16'h0);
      exp_v = model_pop();
      chk("pop_wben", oWbEn, 1);
      chk("pop_addr", oWbAddr, i + 10);
      chk("pop_data", oWbData, exp_v);
    end
    chk("pop_unf", oStackUnf, unf_m);
    chk("pop_ovf_sticky", oStackOvf, ovf_m);

    // RET on empty stack: no redirect
    issue(OP_RET, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("ret_empty_redir", oRedirect, 0);
    chk("ret_empty_ready", oReady, 1);

    // Fill the stack, CALL on full still redirects and drops its entry
    for (int i = 0; i < SD; i++) begin
      a = int'($urandom_range(0, 65535));
      issue(OP_PUSH, 8'd0, DW'(a), 16'h0, 16'h0, 16'h0);
      model_push(a);
    end
    issue(OP_CALL, 8'd0, 16'h0, 16'h0, 16'h0123, 16'h0200);
    model_push(16'h0201);
    chk("callfull_redir", oRedirect, 1);
    chk("callfull_pc", oRedirectPC, 16'h0123);
    @(negedge Clock);
    for (int i = 0; i < SD; i++) begin
      issue(OP_POP, 8'd3, 16'h0, 16'h0, 16'h0, 16'h0);
      chk("drain_data", oWbData, model_pop());
    end
    chk("flags_ovf_sticky", oStackOvf, 1);
    chk("flags_unf_sticky", oStackUnf, 1);

    // MUL
`ifdef ALU_EXEC_MUL_EN
    issue(OP_MUL, 8'd7, 16'd300, 16'd300, 16'h0, 16'h0);
    chk("mul_busy_ready", oReady, 0);
    for (int i = 1; i < DW; i++) begin
      @(negedge Clock);
      chk("mul_busy_ready", oReady, 0);
      chk("mul_busy_nowb", oWbEn, 0);
    end
    @(negedge Clock);
    chk("mul_wben", oWbEn, 1);
    chk("mul_addr", oWbAddr, 7);
    chk("mul_data", oWbData, 16'h5F90);
    chk("mul_ready_after", oReady, 1);
    for (int i = 0; i < 3; i++) begin
      a = int'($urandom_range(0, 65535)); b = int'($urandom_range(0, 65535));
      issue(OP_MUL, 8'd9, DW'(a), DW'(b), 16'h0, 16'h0);
      repeat (DW - 1) @(negedge Clock);
      @(negedge Clock);
      chk("mul_rand_wben", oWbEn, 1);
      chk("mul_rand_data", oWbData, (longint'(a) * longint'(b)) % 65536);
    end
`else
    issue(OP_MUL, 8'd7, 16'd300, 16'd300, 16'h0, 16'h0);
    chk("mul_off_nowb", oWbEn, 0);
    chk("mul_off_ready", oReady, 1);
`endif

    // OUT with idle peripheral
    iPeriphBusy = 1'b0;
    issue(OP_OUT, 8'd0, 16'h1234, 16'h0, 16'h0, 16'h0);
    chk("out_fast_pw", oPeriphWrite, 1);
    chk("out_fast_data", oPeriphData, 16'h1234);
    chk("out_fast_ready", oReady, 1);
    @(negedge Clock);
    chk("out_fast_one_cycle", oPeriphWrite, 0);

    // OUT with busy peripheral for 7 sampled edges
    iPeriphBusy = 1'b1;
    issue(OP_OUT, 8'd0, 16'h0041, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 6; i++) begin
      chk("out_wait_pw", oPeriphWrite, 0);
      chk("out_wait_ready", oReady, 0);
      @(negedge Clock);
    end
    chk("out_wait_pw", oPeriphWrite, 0);
    iPeriphBusy = 1'b0;
    @(negedge Clock);
    chk("out_slow_pw", oPeriphWrite, 1);
    chk("out_slow_data", oPeriphData, 16'h0041);
    @(negedge Clock);
    chk("out_slow_one_cycle", oPeriphWrite, 0);
    chk("out_slow_ready", oReady, 1);

    // Reset in the middle of an OUT wait: no strobe, flags cleared
    iPeriphBusy = 1'b1;
    issue(OP_OUT, 8'd0, 16'h0055, 16'h0, 16'h0, 16'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("rst2_ovf", oStackOvf, 0);
    chk("rst2_unf", oStackUnf, 0);
    chk("rst2_pw", oPeriphWrite, 0);
    @(negedge Clock);
    Reset = 1'b1;
    iPeriphBusy = 1'b0;
    strobes = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      if (oPeriphWrite) strobes++;
    end
    chk("rst2_no_strobe", strobes, 0);
    chk("rst2_ready", oReady, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute/writeback stage for the next-generation MiniAlu-class processor. It accepts one decoded instruction at a time over a valid/ready handshake and executes ALU, branch, CALL/RET and PUSH/POP operations against an internal hardware stack. It produces a registered register-file writeback and a PC redirect. It also drives a stall-aware peripheral write port for the LCD/VGA sinks.

## Interface
- DATA_W, 16, datapath and stack entry width
- ADDR_W, 8, register-file address width
- PC_W, 16, program counter width; must be ≤ DATA_W
- STACK_DEPTH, 16, hardware stack entries; power of two, ≥ 2
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low
- iValid  in  1  decoded instruction present
- oReady  out  1  unit accepts an instruction this cycle
- iOpcode  in  6  operation code, from the package
- iDest  in  ADDR_W  writeback register
- iSrcA, iSrcB  in  DATA_W  source register values
- iImm  in  DATA_W  zero-extended immediate, or branch/call target
- iPC  in  PC_W  address of the presented instruction
- iPeriphBusy  in  1  peripheral sink not ready (LCD busy)
- oWbEn / oWbAddr / oWbData  out  1 / ADDR_W / DATA_W  register writeback
- oRedirect / oRedirectPC  out  1 / PC_W  one-cycle PC redirect
- oPeriphWrite / oPeriphData  out  1 / DATA_W  one-cycle peripheral strobe and data
- oStackOvf, oStackUnf  out  1  sticky error flags

## Operation
- Accept occurs on any edge where iValid && oReady. All outputs are registered.
- States:
  - IDLE: the only state with oReady=1.
  - MUL_BUSY: iterative multiply in progress.
  - PERIPH_WAIT: OUT held while the peripheral is busy.
  - BUBBLE: one cycle, entered after any redirect.
- Single-cycle ops, each writing the result to iDest:
  - ADD: A+B
  - SUB: A−B
  - AND, OR, NOR
  - ADDI: A+iImm
  - STO: iImm
- Arithmetic wraps modulo 2^DATA_W. There are no flags.
- Branches:
  - BLE redirects to iImm when A ≤ B, unsigned.
  - BEQ redirects to iImm when A == B.
  - JMP always redirects to iImm.
  - None of these write back.
- CALL pushes iPC+1, zero-extended, and redirects to iImm.
- RET pops an entry and redirects to its low PC_W bits.
- PUSH pushes A. POP pops an entry and writes it to iDest.
- Stack boundaries:
  - PUSH or CALL on a full stack: entry dropped, oStackOvf set. CALL still redirects.
  - POP on an empty stack: writes 0 and sets oStackUnf.
  - RET on an empty stack: no redirect, sets oStackUnf.
- OUT:
  - If iPeriphBusy=0 at accept, pulse oPeriphWrite with A next cycle and stay in IDLE.
  - Otherwise latch A, go to PERIPH_WAIT, and pulse on the first cycle iPeriphBusy=0, then return to IDLE.
- NOP and undefined opcodes take one cycle with no effect.
- Sticky flags clear only on Reset.

## Timing
- Reset values:
  - All outputs 0, except oReady=1 once Reset is released.
  - Stack pointer 0, state IDLE.
  - An asserted Reset aborts any MUL or OUT in flight; nothing is written.
- Single-cycle op accepted at edge N: oWbEn is high for exactly the cycle following edge N.
- Redirect op accepted at edge N:
  - oRedirect is high for the cycle after edge N, with oReady=0 in that cycle (BUBBLE).
  - The next accept is possible at edge N+2; upstream refetches during the bubble.
- MUL accepted at edge N:
  - oReady=0 for DATA_W cycles.
  - Shift-add runs one bit per edge, N+1 … N+DATA_W.
  - oWbEn is high in the cycle after edge N+DATA_W, carrying the low DATA_W bits of the product.
- OUT: the strobe appears at the earliest cycle after accept in which iPeriphBusy is sampled low. oReady=0 while waiting.
- Stack: push and pop never occur in the same cycle, since there is one op per accept.

## Configuration
- ALU_EXEC_MUL_EN
  - Defined: MUL executes as described above (DATA_W+1 cycle latency).
  - Undefined: the multiplier and MUL_BUSY state are removed; MUL behaves as NOP (one cycle, no writeback).

## Structure
- Package alu_exec_pkg holds:
  - the 6-bit opcode constants (NOP, ADD, SUB, AND, OR, NOR, ADDI, MUL, STO, BLE, BEQ, JMP, CALL, RET, PUSH, POP, OUT);
  - the state encoding.
- Sub-module lifo_stack (DATA_W, STACK_DEPTH):
  - ports: push, pop, data in/out, full, empty;
  - asynchronous active-low reset on the pointer.

## Test plan
Benches run with DATA_W=16 and STACK_DEPTH=4.
- ADD A=0xFFFF, B=0x0002, iDest=5 → next cycle oWbEn=1, oWbAddr=5, oWbData=0x0001.
- BLE A=3, B=3, iImm=0x0040 → oRedirect=1, oRedirectPC=0x0040; oReady low one cycle. A repeat with A=4, B=3 gives no redirect.
- CALL at iPC=0x0010 with iImm=0x0080, then RET → redirects to 0x0080, then to 0x0011.
- Five PUSHes of 1..5, then five POPs → writes 4,3,2,1,0; oStackOvf=1 and oStackUnf=1, both remaining set until Reset.
- MUL A=300, B=300 → oReady low 16 cycles, then oWbData=0x5F90 (90000 mod 65536). With the macro undefined: no writeback and oReady stays high.
- OUT A=0x41 with iPeriphBusy high for 7 cycles → exactly one oPeriphWrite with data 0x41, in the first cycle iPeriphBusy is sampled low. Asserting Reset mid-wait produces no strobe.
